// File: rtl/seq_pkg.sv
// Shared definitions for the control sequencer: control-word bit map, opcodes
// and the microword carried from the microcode ROM to the sequencer.
package seq_pkg;

   localparam int CTRL_W = 16;

   // Control word bit positions, hlt in the MSB down to fi in the LSB.
   localparam int HLT_B  = 15;
   localparam int MI_B   = 14;
   localparam int RI_B   = 13;
   localparam int RO_B   = 12;
   localparam int IO_B   = 11;
   localparam int II_B   = 10;
   localparam int AI_B   = 9;
   localparam int AO_B   = 8;
   localparam int SUMO_B = 7;
   localparam int SUB_B  = 6;
   localparam int BI_B   = 5;
   localparam int OI_B   = 4;
   localparam int CE_B   = 3;
   localparam int CO_B   = 2;
   localparam int J_B    = 1;
   localparam int FI_B   = 0;

   typedef enum logic [3:0] {
      OP_NOP = 4'b0000,
      OP_LDA = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_STA = 4'b0100,
      OP_LDI = 4'b0101,
      OP_JMP = 4'b0110,
      OP_JC  = 4'b0111,
      OP_JZ  = 4'b1000,
      OP_OUT = 4'b1110,
      OP_HLT = 4'b1111
   } opcode_e;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic              last;
   } microword_t;

   function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
      return CTRL_W'(1) << idx;
   endfunction

endpackage

// File: rtl/control_rom.sv
// Combinational microcode table: (opcode, step, flags) -> microword.
// Conditional jumps and the fi strobe exist only when COND_JUMP_EN is defined.
module control_rom
   import seq_pkg::*;
#(
   parameter int STEP_W = 3
) (
   input  logic [3:0]        opcode_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              flag_c_i,
   input  logic              flag_z_i,
   output microword_t        uword_o
);

   localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
   localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
   localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
   localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
   localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

`ifdef COND_JUMP_EN
   localparam logic [CTRL_W-1:0] FI_MASK = cbit(FI_B);
`else
   localparam logic [CTRL_W-1:0] FI_MASK = '0;
   logic unused_flags;
   assign unused_flags = flag_c_i ^ flag_z_i;
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      uword_o = '0;
      if (step_i == T0) begin
         uword_o.ctrl = cbit(MI_B) | cbit(CO_B);
      end else if (step_i == T1) begin
         uword_o.ctrl = cbit(RO_B) | cbit(II_B) | cbit(CE_B);
      end else begin
         // Execute steps end the instruction unless a row below says otherwise;
         // this also retires anything landing on an unused step.
         uword_o.last = 1'b1;
         case (opcode_i)
            OP_LDA: begin
               if (step_i == T2) begin
                  uword_o.ctrl = cbit(IO_B) | cbit(MI_B);
                  uword_o.last = 1'b0;
               end else if (step_i == T3) begin
                  uword_o.ctrl = cbit(RO_B) | cbit(AI_B);
               end
            end
            OP_ADD, OP_SUB: begin
               if (step_i == T2) begin
                  uword_o.ctrl = cbit(IO_B) | cbit(MI_B);
                  uword_o.last = 1'b0;
               end else if (step_i == T3) begin
                  uword_o.ctrl = cbit(RO_B) | cbit(BI_B);
                  uword_o.last = 1'b0;
               end else if (step_i == T4) begin
                  uword_o.ctrl = cbit(SUMO_B) | cbit(AI_B) | FI_MASK
                               | ((opcode_i == OP_SUB) ? cbit(SUB_B) : '0);
               end
            end
            OP_STA: begin
               if (step_i == T2) begin
                  uword_o.ctrl = cbit(IO_B) | cbit(MI_B);
                  uword_o.last = 1'b0;
               end else if (step_i == T3) begin
                  uword_o.ctrl = cbit(AO_B) | cbit(RI_B);
               end
            end
            OP_LDI: if (step_i == T2) uword_o.ctrl = cbit(IO_B) | cbit(AI_B);
            OP_JMP: if (step_i == T2) uword_o.ctrl = cbit(IO_B) | cbit(J_B);
`ifdef COND_JUMP_EN
            OP_JC:  if (step_i == T2 && flag_c_i) uword_o.ctrl = cbit(IO_B) | cbit(J_B);
            OP_JZ:  if (step_i == T2 && flag_z_i) uword_o.ctrl = cbit(IO_B) | cbit(J_B);
`endif
            OP_OUT: if (step_i == T2) uword_o.ctrl = cbit(AO_B) | cbit(OI_B);
            OP_HLT: begin
               // The sequencer latches halt from this word, so it is not a last step.
               if (step_i == T2) begin
                  uword_o.ctrl = cbit(HLT_B);
                  uword_o.last = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer: owns the step counter and halt latch and decodes the
// control word. Optional conditional jumps are enabled by defining COND_JUMP_EN.
module control_sequencer
   import seq_pkg::*;
#(
   parameter int INSN_W    = 8,
   parameter int STEP_W    = 3,
   parameter int MAX_STEPS = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INSN_W-1:0] insn,
   input  logic              prog_mode,
   input  logic              flag_c,
   input  logic              flag_z,
   output logic [CTRL_W-1:0] ctrl,
   output logic [STEP_W-1:0] step
);

   logic [STEP_W-1:0] step_q, step_d;
   logic              halted_q, halted_d;
   microword_t        uword;

   logic unused_insn;
   assign unused_insn = ^insn[INSN_W-5:0];

   control_rom #(
      .STEP_W (STEP_W)
   ) u_rom (
      .opcode_i (insn[INSN_W-1 -: 4]),
      .step_i   (step_q),
      .flag_c_i (flag_c),
      .flag_z_i (flag_z),
      .uword_o  (uword)
   );

   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (prog_mode) begin
         step_d = '0;
      end else if (!halted_q) begin
         if (uword.ctrl[HLT_B]) begin
            halted_d = 1'b1;
         end else if (uword.last || step_q == STEP_W'(MAX_STEPS-1)) begin
            step_d = '0;
         end else begin
            step_d = step_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of the others.
   always_ff @(posedge clk) begin
      if (!rst) begin
         step_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      if (!rst) begin
         ctrl = '0;
      end else if (prog_mode || halted_q) begin
         ctrl = cbit(HLT_B);
      end else begin
         ctrl = uword.ctrl;
      end
   end

   assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected (ctrl, step) pairs are
// queued per scenario and compared each cycle on the falling clock edge.
module tb_control_sequencer;

   localparam logic [15:0] C_HLT  = 16'h8000;
   localparam logic [15:0] C_MI   = 16'h4000;
   localparam logic [15:0] C_RI   = 16'h2000;
   localparam logic [15:0] C_RO   = 16'h1000;
   localparam logic [15:0] C_IO   = 16'h0800;
   localparam logic [15:0] C_II   = 16'h0400;
   localparam logic [15:0] C_AI   = 16'h0200;
   localparam logic [15:0] C_AO   = 16'h0100;
   localparam logic [15:0] C_SUMO = 16'h0080;
   localparam logic [15:0] C_SUB  = 16'h0040;
   localparam logic [15:0] C_BI   = 16'h0020;
   localparam logic [15:0] C_CE   = 16'h0008;
   localparam logic [15:0] C_CO   = 16'h0004;
   localparam logic [15:0] C_J    = 16'h0002;
   localparam logic [15:0] C_FI   = 16'h0001;

`ifdef COND_JUMP_EN
   localparam logic [15:0] FI_EXP = C_FI;
   localparam bit          COND   = 1'b1;
`else
   localparam logic [15:0] FI_EXP = 16'h0000;
   localparam bit          COND   = 1'b0;
`endif

   localparam logic [15:0] W_T0 = C_MI | C_CO;
   localparam logic [15:0] W_T1 = C_RO | C_II | C_CE;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  insn;
   logic        prog_mode;
   logic        flag_c;
   logic        flag_z;
   logic [15:0] ctrl;
   logic [2:0]  step;

   typedef struct {
      logic [15:0] ctrl;
      logic [2:0]  step;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .insn      (insn),
      .prog_mode (prog_mode),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .ctrl      (ctrl),
      .step      (step)
   );

   task automatic push(input logic [15:0] c, input logic [2:0] s, input string tag);
      exp_t e;
      e.ctrl = c;
      e.step = s;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      insn = 8'h1E;
      push(16'h0000, 3'd0, "reset_low_a");
      push(16'h0000, 3'd0, "reset_low_b");
      for (int k = 0; k < 2; k++) begin
         rst = 1'b0;
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (ctrl !== e.ctrl || step !== e.step) begin
            bad++;
            $display("FAIL %s: got ctrl=%h step=%0d want ctrl=%h step=%0d", e.tag, ctrl, step, e.ctrl, e.step);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
   endtask

   task automatic test_lda();
      exp_t e;
      push(W_T0, 3'd0, "lda_t0");
      push(W_T1, 3'd1, "lda_t1");
      push(C_IO | C_MI, 3'd2, "lda_t2");
      push(C_RO | C_AI, 3'd3, "lda_t3");
      push(W_T0, 3'd0, "lda_next_t0");
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (ctrl !== e.ctrl || step !== e.step) begin
            bad++;
            $display("FAIL %s: got ctrl=%h step=%0d want ctrl=%h step=%0d", e.tag, ctrl, step, e.ctrl, e.step);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sub();
      exp_t e;
      insn = 8'h3F;
      pulse_reset();
      push(W_T0, 3'd0, "sub_t0");
      push(W_T1, 3'd1, "sub_t1");
      push(C_IO | C_MI, 3'd2, "sub_t2");
      push(C_RO | C_BI, 3'd3, "sub_t3");
      push(C_SUMO | C_AI | C_SUB | FI_EXP, 3'd4, "sub_t4");
      push(W_T0, 3'd0, "sub_next_t0");
      push(W_T1, 3'd1, "sub_next_t1");
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (ctrl !== e.ctrl || step !== e.step) begin
            bad++;
            $display("FAIL %s: got ctrl=%h step=%0d want ctrl=%h step=%0d", e.tag, ctrl, step, e.ctrl, e.step);
         end
         @(posedge clk); #1;
      end
   endtask

   // Flag is driven opposite during fetch to show only the T2 value matters.
   task automatic test_cond_jump(input logic [7:0] op, input bit use_z, input bit fval, input string tag);
      exp_t e;
      logic [15:0] t2;
      insn = op;
      pulse_reset();
      t2 = (COND && fval) ? (C_IO | C_J) : 16'h0000;
      push(W_T0, 3'd0, {tag, "_t0"});
      push(W_T1, 3'd1, {tag, "_t1"});
      push(t2, 3'd2, {tag, "_t2"});
      push(W_T0, 3'd0, {tag, "_ret_t0"});
      for (int k = 0; k < 4; k++) begin
         if (use_z) flag_z = (k == 2) ? fval : ~fval;
         else       flag_c = (k == 2) ? fval : ~fval;
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (ctrl !== e.ctrl || step !== e.step) begin
            bad++;
            $display("FAIL %s: got ctrl=%h step=%0d want ctrl=%h step=%0d", e.tag, ctrl, step, e.ctrl, e.step);
         end
         @(posedge clk); #1;
      end
      flag_c = 1'b0;
      flag_z = 1'b0;
   endtask

   task automatic test_hlt();
      exp_t e;
      int n;
      insn = 8'hF0;
      pulse_reset();
      push(W_T0, 3'd0, "hlt_t0");
      push(W_T1, 3'd1, "hlt_t1");
      push(C_HLT, 3'd2, "hlt_t2");
      for (int k = 0; k < 20; k++) push(C_HLT, 3'd2, "hlt_frozen");
      push(16'h0000, 3'd2, "hlt_rst_low");
      push(W_T0, 3'd0, "hlt_after_rst_t0");
      push(W_T1, 3'd1, "hlt_after_rst_t1");
      n = sb.size();
      for (int k = 0; k < n; k++) begin
         if (k == 3) insn = 8'h1E;
         rst = (k == 23) ? 1'b0 : 1'b1;
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (ctrl !== e.ctrl || step !== e.step) begin
            bad++;
            $display("FAIL %s: got ctrl=%h step=%0d want ctrl=%h step=%0d", e.tag, ctrl, step, e.ctrl, e.step);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
   endtask

   task automatic test_prog_mode();
      exp_t e;
      insn = 8'h2A;
      pulse_reset();
      push(W_T0, 3'd0, "pm_t0");
      push(W_T1, 3'd1, "pm_t1");
      push(C_IO | C_MI, 3'd2, "pm_t2");
      push(C_HLT, 3'd3, "pm_assert_t3");
      push(C_HLT, 3'd0, "pm_hold_a");
      push(C_HLT, 3'd0, "pm_hold_b");
      push(W_T0, 3'd0, "pm_resume_t0");
      push(W_T1, 3'd1, "pm_resume_t1");
      for (int k = 0; k < 8; k++) begin
         prog_mode = (k >= 3 && k <= 5);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (ctrl !== e.ctrl || step !== e.step) begin
            bad++;
            $display("FAIL %s: got ctrl=%h step=%0d want ctrl=%h step=%0d", e.tag, ctrl, step, e.ctrl, e.step);
         end
         @(posedge clk); #1;
      end
      prog_mode = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      insn      = 8'h00;
      prog_mode = 1'b0;
      flag_c    = 1'b0;
      flag_z    = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_lda();
      test_sub();
      test_cond_jump(8'h75, 1'b0, 1'b1, "jc_taken");
      test_cond_jump(8'h75, 1'b0, 1'b0, "jc_not_taken");
      test_cond_jump(8'h80, 1'b1, 1'b1, "jz_flag_set");
      test_cond_jump(8'h80, 1'b1, 1'b0, "jz_flag_clear");
      test_hlt();
      test_prog_mode();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter INSN_W, default 8, instruction register width; opcode = insn[INSN_W-1 -: 4].
REQ-002 SHALL have parameter STEP_W, default 3, microstep counter width.
REQ-003 SHALL have parameter MAX_STEPS, default 6, hard cap on microsteps per instruction (≤ 2**STEP_W).
REQ-004 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port insn, input, INSN_W, current instruction register contents.
REQ-007 SHALL have port prog_mode, input, 1, programming mode; CPU sequencing suspended.
REQ-008 SHALL have ports flag_c and flag_z, input, 1 each, registered carry and zero flags.
REQ-009 SHALL have port ctrl, output, CTRL_W (16), control word: hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j, fi.
REQ-010 SHALL have port step, output, STEP_W, current microstep (debug).

Function
REQ-011 SHALL hold registered state step_q and halted_q; ctrl SHALL be a combinational decode of (step_q, opcode, flags, halted_q, prog_mode).
REQ-012 SHALL drive fetch steps for every opcode: T0 = {mi,co}; T1 = {ro,ii,ce}.
REQ-013 SHALL decode execute steps from T2: LDA 0001 T2 {io,mi}, T3 {ro,ai}*; ADD 0010 T2 {io,mi}, T3 {ro,bi}, T4 {sumo,ai,fi}*; SUB 0011 as ADD with sub also set in T4*; STA 0100 T2 {io,mi}, T3 {ao,ri}*; LDI 0101 T2 {io,ai}*; JMP 0110 T2 {io,j}*; OUT 1110 T2 {ao,oi}*; HLT 1111 T2 {hlt}. Here * marks the last step.
REQ-014 SHALL decode JC 0111 at T2 as {io,j} when flag_c=1, else an empty word, last in both cases; JZ 1000 SHALL behave the same using flag_z.
REQ-015 SHALL treat all other opcodes as NOP: T2 is an empty word and the last step.
REQ-016 SHALL, on the rising edge ending a last step, set step_q to 0; otherwise step_q SHALL increment.
REQ-017 SHALL force step_q to 0 when step_q = MAX_STEPS-1 regardless of the last marker.
REQ-018 SHALL give instruction latencies in cycles including fetch: LDA 4, ADD 5, SUB 5, STA 4, LDI 3, JMP 3, JC 3, JZ 3, OUT 3, NOP 3.
REQ-019 SHALL set halted_q at the end of HLT T2; while halted_q=1, step_q SHALL freeze and ctrl SHALL be hlt only, until reset.
REQ-020 SHALL, while prog_mode=1, hold step_q at 0 and drive ctrl as hlt only; on deassertion, execution SHALL resume at T0 on the next cycle.
REQ-021 SHALL give prog_mode priority over normal sequencing; rst SHALL have priority over all.
REQ-022 SHALL sample flags combinationally during T2 only; flag changes in other steps SHALL have no effect.

Reset
REQ-023 SHALL, on a rising edge with rst=0, clear step_q and halted_q, including mid-instruction and while halted.
REQ-024 SHALL drive ctrl = 0 while rst=0; after release, the first cycle SHALL be T0.

Configuration
REQ-025 SHALL, with COND_JUMP_EN defined, implement JC, JZ and fi as specified.
REQ-026 SHALL, without COND_JUMP_EN, decode JC and JZ as NOP, hold fi at 0, and leave flag_c and flag_z unused.

Structure
REQ-027 SHALL place in a shared package seq_pkg: CTRL_W, the bit-index constants for each control signal, the opcode enum, and a microword struct (ctrl plus last bit).
REQ-028 SHALL implement the microcode table as combinational sub-module control_rom (opcode, step, flags -> microword); control_sequencer SHALL own all state.

Verification
REQ-029 SHALL verify LDA: reset, then insn=0x1E -> ctrl sequence {mi,co}, {ro,ii,ce}, {io,mi}, {ro,ai}, then {mi,co} at cycle 5.
REQ-030 SHALL verify SUB: insn=0x3F -> T4 ctrl has sumo, ai, sub and fi set; next instruction T0 follows immediately, with no dead cycle.
REQ-031 SHALL verify JC: insn=0x75 with flag_c=1 gives T2 {io,j}; with flag_c=0 T2 ctrl = 0; in both cases step returns to 0 after 3 cycles.
REQ-032 SHALL verify HLT: insn=0xF0 -> hlt=1 from T2 onward and step frozen at 2 for 20 cycles; rst low for 1 edge -> step=0, ctrl=0, then T0.
REQ-033 SHALL verify prog_mode: assert during ADD T3 -> ctrl = hlt only and step=0; deassert -> T0 word {mi,co} on the next cycle.
REQ-034 SHALL verify configuration: without COND_JUMP_EN, insn=0x80 with flag_z=1 -> no j, fi never set, latency 3.
